// File: rtl/bram_tdp_pipe_if.sv
// Port bundle for the two access ports of bram_tdp_pipe.
// The bench drives it through master; the memory sits on the slave side.
interface bram_tdp_pipe_if #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADW        = 5
);

  logic                  en_a;
  logic                  we_a;
  logic [ADW-1:0]        addr_a;
  logic [DATA_WIDTH-1:0] din_a;
  logic [DATA_WIDTH-1:0] dout_a;
  logic                  vld_a;

  logic                  en_b;
  logic                  we_b;
  logic [ADW-1:0]        addr_b;
  logic [DATA_WIDTH-1:0] din_b;
  logic [DATA_WIDTH-1:0] dout_b;
  logic                  vld_b;

  modport master (
    output en_a, we_a, addr_a, din_a,
    output en_b, we_b, addr_b, din_b,
    input  dout_a, vld_a, dout_b, vld_b
  );

  modport slave (
    input  en_a, we_a, addr_a, din_a,
    input  en_b, we_b, addr_b, din_b,
    output dout_a, vld_a, dout_b, vld_b
  );

endinterface

// File: rtl/bram_tdp_pipe.sv
// True dual-port RAM with a pipelined read path, write-write collision flag and
// a self-clearing engine that zeroises the array one word per cycle.
module bram_tdp_pipe #(
  parameter int unsigned DATA_WIDTH     = 12,
  parameter int unsigned ADW            = 5,
  parameter int unsigned DEPTH          = 2 ** ADW,
  parameter int unsigned WR_FIRST       = 0,
  parameter int unsigned OUT_REG        = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clr_i,
  output logic           busy_o,
  output logic           coll_o,
  bram_tdp_pipe_if.slave bus
);

  localparam logic [ADW-1:0] LastAddr = ADW'(DEPTH - 1);
  localparam logic [ADW:0]   DepthW   = (ADW + 1)'(DEPTH);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e         state_q;
  logic           busy_q;
  logic           init_q;
  logic           coll_q;
  logic [ADW-1:0] cnt_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic acc_a, acc_b;
  logic inr_a, inr_b;
  logic wr_a, wr_b;
  logic coll;
  logic [DATA_WIDTH-1:0] rd_a, rd_b;

  logic                  vld1_a_q, vld1_b_q;
  logic [DATA_WIDTH-1:0] dat1_a_q, dat1_b_q;

  // Access decode: nothing is accepted while the clear engine owns the array.
  always_comb begin
    acc_a = bus.en_a & ~busy_q;
    acc_b = bus.en_b & ~busy_q;
    inr_a = {1'b0, bus.addr_a} < DepthW;
    inr_b = {1'b0, bus.addr_b} < DepthW;
    coll  = acc_a & bus.we_a & acc_b & bus.we_b & (bus.addr_a == bus.addr_b);
    wr_a  = acc_a & bus.we_a & inr_a;
    // Port A wins a collision, so B's write is dropped.
    wr_b  = acc_b & bus.we_b & inr_b & ~coll;
  end

  // Read data sampled before this cycle's writes land, except same-port write-first.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (inr_a) begin
      rd_a = (bus.we_a && (WR_FIRST != 0)) ? bus.din_a : mem[bus.addr_a];
    end
    if (inr_b) begin
      rd_b = (bus.we_b && (WR_FIRST != 0)) ? bus.din_b : mem[bus.addr_b];
    end
  end

  // Array has no reset: contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (state_q == StClear) begin
      mem[cnt_q] <= '0;
    end else begin
      if (wr_b) begin
        mem[bus.addr_b] <= bus.din_b;
      end
      if (wr_a) begin
        mem[bus.addr_a] <= bus.din_a;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      init_q  <= (CLEAR_ON_RESET != 0);
      coll_q  <= 1'b0;
    end else begin
      init_q <= 1'b0;
      coll_q <= coll;
      unique case (state_q)
        StIdle: begin
          if (init_q || clr_i) begin
            state_q <= StClear;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        StClear: begin
          if (cnt_q == LastAddr) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // First read stage; data only reloads on an accepted access so it holds otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld1_a_q <= 1'b0;
      vld1_b_q <= 1'b0;
      dat1_a_q <= '0;
      dat1_b_q <= '0;
    end else begin
      vld1_a_q <= acc_a;
      vld1_b_q <= acc_b;
      if (acc_a) begin
        dat1_a_q <= rd_a;
      end
      if (acc_b) begin
        dat1_b_q <= rd_b;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  vld2_a_q, vld2_b_q;
    logic [DATA_WIDTH-1:0] dat2_a_q, dat2_b_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld2_a_q <= 1'b0;
        vld2_b_q <= 1'b0;
        dat2_a_q <= '0;
        dat2_b_q <= '0;
      end else begin
        vld2_a_q <= vld1_a_q;
        vld2_b_q <= vld1_b_q;
        if (vld1_a_q) begin
          dat2_a_q <= dat1_a_q;
        end
        if (vld1_b_q) begin
          dat2_b_q <= dat1_b_q;
        end
      end
    end

    assign bus.vld_a  = vld2_a_q;
    assign bus.vld_b  = vld2_b_q;
    assign bus.dout_a = dat2_a_q;
    assign bus.dout_b = dat2_b_q;
  end else begin : g_no_out_reg
    assign bus.vld_a  = vld1_a_q;
    assign bus.vld_b  = vld1_b_q;
    assign bus.dout_a = dat1_a_q;
    assign bus.dout_b = dat1_b_q;
  end

  assign busy_o = busy_q;
  assign coll_o = coll_q;

endmodule

// File: tb/tb_bram_tdp_pipe.sv
// Scoreboard bench: dut0 uses default parameters, dut1 is DEPTH=20, write-first,
// no output register and no automatic clear.
module tb_bram_tdp_pipe;

  typedef struct {
    logic [11:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr0 = 1'b0, clr1 = 1'b0;
  logic busy0, busy1, coll0, coll1;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int ncoll0 = 0, ncoll1 = 0, nbusy1 = 0;

  exp_t q0a[$], q0b[$], q1a[$], q1b[$];
  exp_t e0a, e0b, e1a, e1b;

  bram_tdp_pipe_if #(.DATA_WIDTH(12), .ADW(5)) b0 ();
  bram_tdp_pipe_if #(.DATA_WIDTH(12), .ADW(5)) b1 ();

  bram_tdp_pipe #(
    .DATA_WIDTH(12),
    .ADW(5)
  ) dut0 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (clr0),
    .busy_o(busy0),
    .coll_o(coll0),
    .bus   (b0)
  );

  bram_tdp_pipe #(
    .DATA_WIDTH(12),
    .ADW(5),
    .DEPTH(20),
    .WR_FIRST(1),
    .OUT_REG(0),
    .CLEAR_ON_RESET(0)
  ) dut1 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (clr1),
    .busy_o(busy1),
    .coll_o(coll1),
    .bus   (b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitors: pop the oldest expectation on every valid pulse.
  always @(negedge clk) if (b0.vld_a) begin
    if (q0a.size() == 0) chk("d0a_unexpected_vld", 1, 0);
    else begin
      e0a = q0a.pop_front();
      chk("d0a_data", int'(b0.dout_a), int'(e0a.data));
      chk("d0a_latency", cyc, e0a.cyc);
    end
  end
  always @(negedge clk) if (b0.vld_b) begin
    if (q0b.size() == 0) chk("d0b_unexpected_vld", 1, 0);
    else begin
      e0b = q0b.pop_front();
      chk("d0b_data", int'(b0.dout_b), int'(e0b.data));
      chk("d0b_latency", cyc, e0b.cyc);
    end
  end
  always @(negedge clk) if (b1.vld_a) begin
    if (q1a.size() == 0) chk("d1a_unexpected_vld", 1, 0);
    else begin
      e1a = q1a.pop_front();
      chk("d1a_data", int'(b1.dout_a), int'(e1a.data));
      chk("d1a_latency", cyc, e1a.cyc);
    end
  end
  always @(negedge clk) if (b1.vld_b) begin
    if (q1b.size() == 0) chk("d1b_unexpected_vld", 1, 0);
    else begin
      e1b = q1b.pop_front();
      chk("d1b_data", int'(b1.dout_b), int'(e1b.data));
      chk("d1b_latency", cyc, e1b.cyc);
    end
  end

  always @(negedge clk) begin
    if (coll0) ncoll0++;
    if (coll1) ncoll1++;
    if (busy1) nbusy1++;
  end

  // One-cycle access on dut d; ea/eb are the expected read-back values.
  task automatic drive(input int d,
                       input logic ena, input logic wea, input logic [4:0] aa,
                       input logic [11:0] da, input logic [11:0] ea,
                       input logic enb, input logic web, input logic [4:0] ab,
                       input logic [11:0] db, input logic [11:0] eb);
    @(posedge clk); #1;
    if (d == 0) begin
      b0.en_a = ena; b0.we_a = wea; b0.addr_a = aa; b0.din_a = da;
      b0.en_b = enb; b0.we_b = web; b0.addr_b = ab; b0.din_b = db;
      if (ena) q0a.push_back('{data: ea, cyc: cyc + 2});
      if (enb) q0b.push_back('{data: eb, cyc: cyc + 2});
    end else begin
      b1.en_a = ena; b1.we_a = wea; b1.addr_a = aa; b1.din_a = da;
      b1.en_b = enb; b1.we_b = web; b1.addr_b = ab; b1.din_b = db;
      if (ena) q1a.push_back('{data: ea, cyc: cyc + 1});
      if (enb) q1b.push_back('{data: eb, cyc: cyc + 1});
    end
    @(posedge clk); #1;
    b0.en_a = 1'b0; b0.en_b = 1'b0;
    b1.en_a = 1'b0; b1.en_b = 1'b0;
  endtask

  task automatic count_busy(input int d, output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((d == 0) ? busy0 : busy1) n++;
      else if (n > 0) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    {b0.en_a, b0.we_a, b0.addr_a, b0.din_a, b0.en_b, b0.we_b, b0.addr_b, b0.din_b} = '0;
    {b1.en_a, b1.we_a, b1.addr_a, b1.din_a, b1.en_b, b1.we_b, b1.addr_b, b1.din_b} = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_vld0", int'({b0.vld_a, b0.vld_b}), 0);
    chk("rst_coll0", int'(coll0), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Automatic clear after reset release on dut0 only.
    count_busy(0, n);
    chk("d0_auto_clear_cycles", n, 32);
    chk("d1_no_auto_clear", nbusy1, 0);
    for (int i = 0; i < 32; i++) drive(0, 1, 0, 5'(i), 0, 0, 1, 0, 5'(31 - i), 0, 0);

    // Write on A, read back on B two cycles later.
    drive(0, 1, 1, 5'd5, 12'hABC, 12'h000, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 5'd5, 0, 12'hABC);

    // Write-write collision: A wins, coll pulses once the next cycle.
    drive(0, 1, 1, 5'd7, 12'h111, 12'h000, 1, 1, 5'd7, 12'h222, 12'h000);
    chk("d0_coll_pulse", int'(coll0), 1);
    @(posedge clk); #1;
    chk("d0_coll_drop", int'(coll0), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 5'd7, 0, 12'h111);

    // Read-during-write, read-first dut0.
    drive(0, 1, 1, 5'd3, 12'h055, 12'h000, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 5'd3, 12'h0AA, 12'h055, 1, 0, 5'd3, 0, 12'h055);
    drive(0, 1, 0, 5'd3, 0, 12'h0AA, 0, 0, 0, 0, 0);

    // dut1: explicit clear of 20 words.
    @(posedge clk); #1 clr1 = 1'b1;
    @(posedge clk); #1 clr1 = 1'b0;
    count_busy(1, n);
    chk("d1_clear_cycles", n, 20);

    // Out-of-range write and read on dut1.
    drive(1, 1, 1, 5'd25, 12'hFFF, 12'h000, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 5'd25, 0, 12'h000);
    for (int i = 0; i < 20; i++) drive(1, 1, 0, 5'(i), 0, 0, 1, 0, 5'(19 - i), 0, 0);

    // Read-during-write, write-first dut1.
    drive(1, 1, 1, 5'd3, 12'h055, 12'h055, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 5'd3, 12'h0AA, 12'h0AA, 1, 0, 5'd3, 0, 12'h055);
    drive(1, 1, 0, 5'd3, 0, 12'h0AA, 0, 0, 0, 0, 0);

    // Reset in the middle of a clear on dut0.
    drive(0, 1, 1, 5'd30, 12'h3C3, 12'h000, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 5'd7, 0, 12'h111, 1, 0, 5'd30, 0, 12'h3C3);
    repeat (3) @(posedge clk);
    #1 clr0 = 1'b1;
    @(posedge clk); #1 clr0 = 1'b0;
    n = 0;
    for (int i = 0; i < 50 && n < 10; i++) begin
      @(negedge clk);
      if (busy0) n++;
    end
    chk("d0_clear_reached_10", n, 10);
    #1 rst_n = 1'b0;
    #1;
    chk("midclr_busy0", int'(busy0), 0);
    chk("midclr_dout_a0", int'(b0.dout_a), 0);
    chk("midclr_dout_b0", int'(b0.dout_b), 0);
    chk("midclr_vld0", int'({b0.vld_a, b0.vld_b}), 0);
    chk("midclr_dout_a1", int'(b1.dout_a), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    count_busy(0, n);
    chk("d0_reclear_cycles", n, 32);
    drive(0, 1, 0, 5'd30, 0, 12'h000, 1, 0, 5'd5, 0, 12'h000);
    // dut1 memory survives reset.
    drive(1, 1, 0, 5'd3, 0, 12'h0AA, 0, 0, 0, 0, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("d0_coll_total", ncoll0, 1);
    chk("d1_coll_total", ncoll1, 0);
    chk("q_empty", q0a.size() + q0b.size() + q1a.size() + q1b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
